// File: rtl/output_port_decap_0_if.sv
// ---------------------------------------------------------------------------
// output_port_decap_0_if
//
// Bundles the two bus sides of the output-port decapsulator:
//   - flit FIFO read side : empty_0, dout_0 (from FIFO), rd_en_0 (to FIFO)
//   - packet side         : pkt_valid, pkt_header, pkt_dst_addr, pkt_data,
//                           pkt_err, busy (to arbiter), pkt_ready (from arbiter)
//
// Handshake rules (both sides):
//   - A FIFO read is accepted on a rising edge where rd_en_0 && !empty_0.
//     dout_0 carries the accepted flit during the following cycle.
//   - A packet transfers on a rising edge where pkt_valid && pkt_ready.
//     Once pkt_valid is high, it stays high and the pkt_* fields stay
//     stable until that transfer. pkt_ready while pkt_valid is low has
//     no effect.
//
// Modports:
//   master - the decapsulator
//   slave  - the environment (FIFO plus output arbiter)
// ---------------------------------------------------------------------------
interface output_port_decap_0_if #(
    parameter int DATA_W = 1024,
    parameter int FLIT_W = 64,
    parameter int ADDR_W = 10,
    parameter int HDR_W  = 9
);
    logic              empty_0;
    logic [FLIT_W-1:0] dout_0;
    logic              rd_en_0;

    logic              pkt_valid;
    logic              pkt_ready;
    logic [HDR_W-1:0]  pkt_header;
    logic [ADDR_W-1:0] pkt_dst_addr;
    logic [DATA_W-1:0] pkt_data;
    logic              pkt_err;
    logic              busy;

    modport master (
        input  empty_0,
        input  dout_0,
        input  pkt_ready,
        output rd_en_0,
        output pkt_valid,
        output pkt_header,
        output pkt_dst_addr,
        output pkt_data,
        output pkt_err,
        output busy
    );

    modport slave (
        output empty_0,
        output dout_0,
        output pkt_ready,
        input  rd_en_0,
        input  pkt_valid,
        input  pkt_header,
        input  pkt_dst_addr,
        input  pkt_data,
        input  pkt_err,
        input  busy
    );
endinterface

// File: rtl/output_port_decap_0.sv
// ---------------------------------------------------------------------------
// output_port_decap_0
//
// Receive-side decapsulator. Drains one header flit plus DATA_W/FLIT_W
// payload flits from the input port's flit FIFO and presents them as one
// parallel packet to the output arbiter.
//
// Flit layout:
//   header flit : [ADDR_W-1:0] dst_addr, [ADDR_W+HDR_W-1:ADDR_W] header,
//                 upper bits reserved (any nonzero bit raises pkt_err)
//   payload i   : lands in pkt_data[DATA_W-1-FLIT_W*(i-1) -: FLIT_W],
//                 so the first payload flit carries the MSBs
//
// Ports:
//   clk_0       single clock, rising edge
//   rst_n_0     synchronous active-low reset; also blocks rd_en_0 while low
//   bus         output_port_decap_0_if.master (FIFO read + packet side)
//   dbg_state   current FSM state (0 = RECV, 1 = HOLD)
//   dbg_rd_cnt  reads issued for the current packet
//   dbg_rx_cnt  flits captured for the current packet
// ---------------------------------------------------------------------------
module output_port_decap_0 #(
    parameter int DATA_W = 1024,
    parameter int FLIT_W = 64,
    parameter int ADDR_W = 10,
    parameter int HDR_W  = 9
) (
    input  logic                    clk_0,
    input  logic                    rst_n_0,
    output_port_decap_0_if.master   bus,
    output logic                    dbg_state,
    output logic [4:0]              dbg_rd_cnt,
    output logic [4:0]              dbg_rx_cnt
);
    localparam int NUM_FLITS = DATA_W / FLIT_W;     // payload flits
    localparam int PKT_FLITS = NUM_FLITS + 1;       // header + payload
    localparam int CNT_W     = 5;                   // holds 0..PKT_FLITS

    localparam logic [CNT_W-1:0] RD_LIMIT = CNT_W'(PKT_FLITS);
    localparam logic [CNT_W-1:0] LAST_RX  = CNT_W'(NUM_FLITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        RECV = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic [CNT_W-1:0]  rx_cnt_q;
    logic              rd_d1_q;     // dout_0 holds an accepted flit this cycle
    logic              rd_en;
    logic              rd_acc;

    logic [HDR_W-1:0]  hdr_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    // -----------------------------------------------------------------------
    // Next state and FIFO read request
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            RECV: begin
                rd_en = !bus.empty_0 && (rd_cnt_q < RD_LIMIT);
                // The 17th flit is being captured at this edge.
                if (rd_d1_q && (rx_cnt_q == LAST_RX)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.pkt_ready) begin
                    state_d = RECV;
                end
            end
            default: state_d = RECV;
        endcase
        // Reset must not pop flits that would then be thrown away.
        if (!rst_n_0) begin
            rd_en = 1'b0;
        end
    end

    assign rd_acc = rd_en && !bus.empty_0;

    // -----------------------------------------------------------------------
    // State, counters and read-data strobe
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_0) begin
        if (!rst_n_0) begin
            state_q  <= RECV;
            rd_cnt_q <= '0;
            rx_cnt_q <= '0;
            rd_d1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == HOLD) begin
                rd_d1_q <= 1'b0;
                if (bus.pkt_ready) begin
                    rd_cnt_q <= '0;
                    rx_cnt_q <= '0;
                end
            end else begin
                rd_d1_q <= rd_acc;
                if (rd_acc) begin
                    rd_cnt_q <= rd_cnt_q + CNT_ONE;
                end
                if (rd_d1_q) begin
                    rx_cnt_q <= rx_cnt_q + CNT_ONE;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Packet assembly. Fields keep their last values after delivery until
    // the next packet overwrites them slot by slot.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_0) begin
        if (!rst_n_0) begin
            hdr_q  <= '0;
            dst_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else if ((state_q == RECV) && rd_d1_q) begin
            if (rx_cnt_q == '0) begin
                dst_q <= bus.dout_0[ADDR_W-1:0];
                hdr_q <= bus.dout_0[ADDR_W+HDR_W-1:ADDR_W];
                err_q <= |bus.dout_0[FLIT_W-1:ADDR_W+HDR_W];
            end
            for (int i = 0; i < NUM_FLITS; i++) begin
                if (rx_cnt_q == CNT_W'(i + 1)) begin
                    data_q[DATA_W-1-FLIT_W*i -: FLIT_W] <= bus.dout_0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.rd_en_0      = rd_en;
    assign bus.pkt_valid    = (state_q == HOLD);
    assign bus.pkt_header   = hdr_q;
    assign bus.pkt_dst_addr = dst_q;
    assign bus.pkt_data     = data_q;
    assign bus.pkt_err      = err_q;
    assign bus.busy         = (state_q == HOLD) || (rd_cnt_q != '0);

    assign dbg_state  = (state_q == HOLD);
    assign dbg_rd_cnt = rd_cnt_q;
    assign dbg_rx_cnt = rx_cnt_q;
endmodule
